// File: rtl/mult_mac_ctrl.sv
// Sequenced 16x16 multiply / multiply-accumulate unit.
// Sign-magnitude around one unsigned multiplier, 32-bit sticky-overflow accumulator.

module mult16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  assign p = {16'd0, a} * {16'd0, b};

endmodule

module mult_mac_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        clr_acc,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] acc,
  output logic        ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [15:0] mag_a;
  logic [15:0] mag_b;
  logic        neg;
  logic [31:0] prod_q;
  logic [31:0] prod_w;

  logic [15:0] a_mag;
  logic [15:0] b_mag;
  logic [31:0] p_fix;
  logic [32:0] sum;
  logic        s_ovf;
  logic        ovf_hit;

  mult16x16 u_mult (
    .a (mag_a),
    .b (mag_b),
    .p (prod_w)
  );

  // Operand magnitudes at capture; 0x8000 negates to itself.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (op[0] && a[15]) a_mag = ~a + 16'd1;
    if (op[0] && b[15]) b_mag = ~b + 16'd1;
  end

  // Sign fix-up, accumulate and overflow detection for the FIX cycle.
  always_comb begin
    p_fix   = neg ? (~prod_q + 32'd1) : prod_q;
    sum     = {1'b0, acc} + {1'b0, p_fix};
    s_ovf   = (acc[31] == p_fix[31]) && (sum[31] != acc[31]);
    ovf_hit = op_q[1] && (op_q[0] ? s_ovf : sum[32]);
  end

  // Control FSM plus all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 2'd0;
      mag_a  <= 16'd0;
      mag_b  <= 16'd0;
      neg    <= 1'b0;
      prod_q <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
      acc    <= 32'd0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_acc) begin
            acc <= 32'd0;
            ovf <= 1'b0;
          end
          if (start) begin
            state <= MUL;
            busy  <= 1'b1;
            op_q  <= op;
            mag_a <= a_mag;
            mag_b <= b_mag;
            neg   <= op[0] & (a[15] ^ b[15]);
          end
        end
        MUL: begin
          prod_q <= prod_w;
          state  <= FIX;
        end
        FIX: begin
          result <= p_fix;
          if (op_q[1]) begin
            acc <= sum[31:0];
            if (ovf_hit) ovf <= 1'b1;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_mac_ctrl.sv
// Bench for mult_mac_ctrl: directed plan steps then random ops
// against an arithmetic reference model.

module tb_mult_mac_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        clr_acc;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] acc;
  logic        ovf;

  int compared;
  int mismatched;

  logic [31:0] m_res;
  logic [31:0] m_acc;
  logic        m_ovf;

  mult_mac_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .clr_acc (clr_acc),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .acc     (acc),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model(input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic clr);
    longint sx, sy, pr, s;
    logic [31:0] p;
    if (clr) begin
      m_acc = 0;
      m_ovf = 0;
    end
    sx = o[0] ? longint'($signed(x)) : longint'(x);
    sy = o[0] ? longint'($signed(y)) : longint'(y);
    pr = sx * sy;
    p  = pr[31:0];
    m_res = p;
    if (o[1]) begin
      if (o[0]) begin
        s = longint'($signed(m_acc)) + longint'($signed(p));
        if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1;
      end else begin
        s = longint'({32'd0, m_acc}) + longint'({32'd0, p});
        if (s >= 64'sd4294967296) m_ovf = 1;
      end
      m_acc = m_acc + p;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".acc"}, acc, m_acc);
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  // One operation; call just after a rising edge (+#1).
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic clr, input logic poke);
    start = 1; op = o; a = x; b = y; clr_acc = clr;
    @(posedge clk); #1;
    chk({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    chk({tag, ".done0"}, {31'd0, done}, 32'd0);
    start = poke; clr_acc = poke;
    op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
    @(posedge clk); #1;
    chk({tag, ".busy1"}, {31'd0, busy}, 32'd1);
    chk({tag, ".done1"}, {31'd0, done}, 32'd0);
    start = 0; clr_acc = 0;
    @(posedge clk); #1;
    model(o, x, y, clr);
    chk({tag, ".done2"}, {31'd0, done}, 32'd1);
    chk({tag, ".busy2"}, {31'd0, busy}, 32'd0);
    check_outs(tag);
  endtask

  task automatic idle_cycle();
    start = 0; clr_acc = 0;
    @(posedge clk); #1;
  endtask

  logic [15:0] edges [4];

  initial begin
    compared = 0; mismatched = 0;
    m_res = 0; m_acc = 0; m_ovf = 0;
    rst = 1; start = 0; op = 0; a = 0; b = 0; clr_acc = 0;
    edges[0] = 16'h8000; edges[1] = 16'hFFFF;
    edges[2] = 16'h0000; edges[3] = 16'h7FFF;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    check_outs("rst");
    rst = 0;
    idle_cycle();

    do_op("umul", 2'b00, 16'hFFFF, 16'hFFFF, 0, 0);
    chk("umul.val", result, 32'hFFFE0001);
    do_op("smul1", 2'b01, 16'hFFFD, 16'h0005, 0, 0);
    chk("smul1.val", result, 32'hFFFFFFF1);
    do_op("smul2", 2'b01, 16'h8000, 16'h8000, 0, 0);
    chk("smul2.val", result, 32'h40000000);
    do_op("smul3", 2'b01, 16'h8000, 16'h0001, 0, 0);
    chk("smul3.val", result, 32'hFFFF8000);

    clr_acc = 1;
    @(posedge clk); #1;
    clr_acc = 0;
    m_acc = 0; m_ovf = 0;
    chk("clr.acc", acc, 32'd0);
    do_op("smac1", 2'b11, 16'd100, 16'd200, 0, 0);
    chk("smac1.acc", acc, 32'h00004E20);
    do_op("smac2", 2'b11, 16'hFFCE, 16'h0190, 0, 0);
    chk("smac2.acc", acc, 32'd0);
    chk("smac2.res", result, 32'hFFFFB1E0);

    do_op("umac1", 2'b10, 16'hFFFF, 16'hFFFF, 1, 0);
    do_op("umac2", 2'b10, 16'hFFFF, 16'hFFFF, 0, 0);
    chk("umac2.acc", acc, 32'hFFFC0002);
    chk("umac2.ovf", {31'd0, ovf}, 32'd1);
    do_op("umul_keep", 2'b00, 16'd3, 16'd3, 0, 0);
    chk("keep.ovf", {31'd0, ovf}, 32'd1);
    clr_acc = 1;
    @(posedge clk); #1;
    clr_acc = 0;
    m_acc = 0; m_ovf = 0;
    check_outs("clr2");

    do_op("poke", 2'b10, 16'd5, 16'd7, 0, 1);
    idle_cycle();
    chk("poke.nodone", {31'd0, done}, 32'd0);
    chk("poke.idle", {31'd0, busy}, 32'd0);
    check_outs("poke");

    do_op("pre", 2'b10, 16'd16, 16'd16, 1, 0);
    chk("pre.acc", acc, 32'h100);
    do_op("clrstart", 2'b10, 16'd3, 16'd4, 1, 0);
    chk("clrstart.acc", acc, 32'h0000000C);

    start = 1; op = 2'b10; a = 16'd9; b = 16'd9;
    @(posedge clk); #1;
    start = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_res = 0; m_acc = 0; m_ovf = 0;
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    chk("rstmid.done", {31'd0, done}, 32'd0);
    check_outs("rstmid");
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("rstmid.nodone", {31'd0, done}, 32'd0);
    end
    do_op("after", 2'b00, 16'd7, 16'd6, 0, 0);
    chk("after.val", result, 32'd42);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)]
                                      : 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)]
                                      : 16'($urandom);
      do_op("rand", 2'($urandom), x, y,
            ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
